iid_allocator: RTL and testbench

- Parametrised successor to the debug instruction-id counter: allocates monotonically increasing instruction IDs for up to LANES fetched instructions per cycle.
- Also tracks in-order retirement and rolls the allocator back on pipeline flush.
- Sits between fetch and the debug trace / commit logic; IDs wrap modulo 2^WIDTH.

---
 rtl/iid_allocator.sv | 96 +++++++++
 tb/tb_iid_allocator.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iid_allocator.sv
// Instruction-ID allocator: hands out up to LANES consecutive IDs per cycle,
// retires them in order, and rewinds the allocation point on pipeline flush.
module iid_allocator #(
    parameter int WIDTH        = 64,
    parameter int LANES        = 2,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [$clog2(LANES+1)-1:0]        alloc_cnt,
    output logic                              alloc_ready,
    output logic [LANES*WIDTH-1:0]            alloc_ids,
    input  logic                              commit_valid,
    input  logic [WIDTH-1:0]                  commit_id,
    input  logic                              flush_valid,
    input  logic [WIDTH-1:0]                  flush_id,
    output logic [WIDTH-1:0]                  next_id,
    output logic [WIDTH-1:0]                  retire_id,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              commit_err,
    output logic                              flush_err
);
    localparam int CW = $clog2(LANES + 1);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    // One extra bit so inflight + alloc_cnt cannot overflow the capacity test.
    localparam int SW = IW + 1;

    logic [WIDTH-1:0] next_id_reg, next_id_next;
    logic [WIDTH-1:0] retire_id_reg, retire_id_next;
    logic             commit_err_reg, commit_err_next;
    logic             flush_err_reg, flush_err_next;

    logic [CW-1:0]    eff_cnt;
    logic             commit_ok;
    logic [WIDTH-1:0] retire_post;
    logic [WIDTH-1:0] flush_dist;
    logic [WIDTH-1:0] flush_window;
    logic             flush_ok;
    logic             alloc_ready_c;

    assign inflight = IW'(next_id_reg - retire_id_reg);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign alloc_ids[gi*WIDTH +: WIDTH] = next_id_reg + WIDTH'(gi);
        end
    endgenerate

    always_comb begin
        // Out-of-range requests behave exactly like an idle cycle.
        eff_cnt       = (alloc_cnt > CW'(LANES)) ? '0 : alloc_cnt;
        alloc_ready_c = !flush_valid &&
                        ((SW'(inflight) + SW'(eff_cnt)) <= SW'(MAX_INFLIGHT));

        commit_ok   = commit_valid && (inflight != '0) && (commit_id == retire_id_reg);
        retire_post = commit_ok ? (retire_id_reg + WIDTH'(1)) : retire_id_reg;

        // The flush target must lie inside the post-commit window [r', n];
        // flush_id == r'-1 gives distance 0 and empties the window.
        flush_dist   = flush_id + WIDTH'(1) - retire_post;
        flush_window = next_id_reg - retire_post;
        flush_ok     = flush_valid && (flush_dist <= flush_window);

        retire_id_next  = retire_post;
        commit_err_next = commit_err_reg | (commit_valid && !commit_ok);
        flush_err_next  = flush_err_reg | (flush_valid && !flush_ok);

        next_id_next = next_id_reg;
        if (flush_ok) begin
            next_id_next = flush_id + WIDTH'(1);
        end else if (alloc_ready_c && (eff_cnt != '0)) begin
            next_id_next = next_id_reg + WIDTH'(eff_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            next_id_reg    <= '0;
            retire_id_reg  <= '0;
            commit_err_reg <= 1'b0;
            flush_err_reg  <= 1'b0;
        end else begin
            next_id_reg    <= next_id_next;
            retire_id_reg  <= retire_id_next;
            commit_err_reg <= commit_err_next;
            flush_err_reg  <= flush_err_next;
        end
    end

    assign alloc_ready = alloc_ready_c;
    assign next_id     = next_id_reg;
    assign retire_id   = retire_id_reg;
    assign commit_err  = commit_err_reg;
    assign flush_err   = flush_err_reg;

endmodule

// File: tb/tb_iid_allocator.sv
// Bench for iid_allocator: a 64-bit instance and a 4-bit instance (for wrap),
// each checked every cycle against a queue-of-outstanding-IDs model.
module tb_iid_allocator;
    localparam int W0 = 64, L0 = 2, M0 = 16;
    localparam int W1 = 4,  L1 = 2, M1 = 8;
    localparam int C0 = $clog2(L0 + 1), I0 = $clog2(M0 + 1);
    localparam int C1 = $clog2(L1 + 1), I1 = $clog2(M1 + 1);
    localparam logic [63:0] MASK0 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MASK1 = (64'd1 << W1) - 64'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst0 = 1'b1, rst1 = 1'b1;
    logic [C0-1:0]     ac0 = '0;
    logic [C1-1:0]     ac1 = '0;
    logic              rdy0, rdy1;
    logic [L0*W0-1:0]  ids0;
    logic [L1*W1-1:0]  ids1;
    logic              cv0 = 1'b0, cv1 = 1'b0, fv0 = 1'b0, fv1 = 1'b0;
    logic [W0-1:0]     cid0 = '0, fid0 = '0, nid0, rid0;
    logic [W1-1:0]     cid1 = '0, fid1 = '0, nid1, rid1;
    logic [I0-1:0]     inf0;
    logic [I1-1:0]     inf1;
    logic              ce0, fe0, ce1, fe1;

    iid_allocator #(.WIDTH(W0), .LANES(L0), .MAX_INFLIGHT(M0)) dut0 (
        .clk(clk), .reset(rst0), .alloc_cnt(ac0), .alloc_ready(rdy0), .alloc_ids(ids0),
        .commit_valid(cv0), .commit_id(cid0), .flush_valid(fv0), .flush_id(fid0),
        .next_id(nid0), .retire_id(rid0), .inflight(inf0),
        .commit_err(ce0), .flush_err(fe0));

    iid_allocator #(.WIDTH(W1), .LANES(L1), .MAX_INFLIGHT(M1)) dut1 (
        .clk(clk), .reset(rst1), .alloc_cnt(ac1), .alloc_ready(rdy1), .alloc_ids(ids1),
        .commit_valid(cv1), .commit_id(cid1), .flush_valid(fv1), .flush_id(fid1),
        .next_id(nid1), .retire_id(rid1), .inflight(inf1),
        .commit_err(ce1), .flush_err(fe1));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: the list of outstanding IDs (oldest first) plus the next free ID.
    logic [63:0] mq0[$];
    logic [63:0] mq1[$];
    logic [63:0] mn0 = '0, mn1 = '0;
    logic        mce0 = 1'b0, mfe0 = 1'b0, mce1 = 1'b0, mfe1 = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready(input int size, input int cnt, input logic fv,
                                       input int lanes, input int maxi);
        int eff;
        eff = (cnt > lanes) ? 0 : cnt;
        return !fv && (size + eff <= maxi);
    endfunction

    task automatic model_step(input int inst, input logic rst, input int cnt,
                              input logic cv, input logic [63:0] cid,
                              input logic fv, input logic [63:0] fid);
        logic [63:0] q[$];
        logic [63:0] n, mask, r;
        logic        ce, fe;
        int          lanes, maxi, kk;
        bit          rdy, ok;
        if (inst == 0) begin
            q = mq0; n = mn0; ce = mce0; fe = mfe0; mask = MASK0; lanes = L0; maxi = M0;
        end else begin
            q = mq1; n = mn1; ce = mce1; fe = mfe1; mask = MASK1; lanes = L1; maxi = M1;
        end
        if (rst) begin
            q.delete(); n = '0; ce = 1'b0; fe = 1'b0;
        end else begin
            rdy = model_ready(q.size(), cnt, fv, lanes, maxi);
            if (cv) begin
                if (q.size() != 0 && q[0] == cid) void'(q.pop_front());
                else ce = 1'b1;
            end
            if (fv) begin
                r  = (q.size() == 0) ? n : q[0];
                ok = 1'b0;
                kk = 0;
                if (fid == ((r - 64'd1) & mask)) begin
                    q.delete(); n = r; ok = 1'b1;
                end else begin
                    for (int k = 0; k < q.size(); k++)
                        if (!ok && q[k] == fid) begin ok = 1'b1; kk = k; end
                    if (ok) begin
                        while (q.size() > kk + 1) void'(q.pop_back());
                        n = (fid + 64'd1) & mask;
                    end
                end
                if (!ok) fe = 1'b1;
            end else if (rdy) begin
                for (int i = 0; i < ((cnt > lanes) ? 0 : cnt); i++) begin
                    q.push_back(n);
                    n = (n + 64'd1) & mask;
                end
            end
        end
        if (inst == 0) begin mq0 = q; mn0 = n; mce0 = ce; mfe0 = fe; end
        else begin mq1 = q; mn1 = n; mce1 = ce; mfe1 = fe; end
    endtask

    always @(posedge clk) begin
        model_step(0, rst0, int'(ac0), cv0, 64'(cid0), fv0, 64'(fid0));
        model_step(1, rst1, int'(ac1), cv1, 64'(cid1), fv1, 64'(fid1));
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("next_id0", 64'(nid0), mn0);
            chk("retire_id0", 64'(rid0), (mq0.size() == 0) ? mn0 : mq0[0]);
            chk("inflight0", 64'(inf0), 64'(mq0.size()));
            chk("commit_err0", 64'(ce0), 64'(mce0));
            chk("flush_err0", 64'(fe0), 64'(mfe0));
            chk("alloc_ready0", 64'(rdy0), 64'(model_ready(mq0.size(), int'(ac0), fv0, L0, M0)));
            for (int i = 0; i < L0; i++)
                chk("alloc_ids0", 64'(ids0[i*W0 +: W0]), (mn0 + 64'(i)) & MASK0);
            chk("next_id1", 64'(nid1), mn1);
            chk("retire_id1", 64'(rid1), (mq1.size() == 0) ? mn1 : mq1[0]);
            chk("inflight1", 64'(inf1), 64'(mq1.size()));
            chk("commit_err1", 64'(ce1), 64'(mce1));
            chk("flush_err1", 64'(fe1), 64'(mfe1));
            chk("alloc_ready1", 64'(rdy1), 64'(model_ready(mq1.size(), int'(ac1), fv1, L1, M1)));
            for (int i = 0; i < L1; i++)
                chk("alloc_ids1", 64'(ids1[i*W1 +: W1]), (mn1 + 64'(i)) & MASK1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input int cnt, input logic cv, input logic [63:0] cid,
                        input logic fv, input logic [63:0] fid);
        ac0 = C0'(cnt); cv0 = cv; cid0 = W0'(cid); fv0 = fv; fid0 = W0'(fid);
        #1;
    endtask

    task automatic set1(input int cnt, input logic cv, input logic [63:0] cid,
                        input logic fv, input logic [63:0] fid);
        ac1 = C1'(cnt); cv1 = cv; cid1 = W1'(cid); fv1 = fv; fid1 = W1'(fid);
        #1;
    endtask

    task automatic reset0();
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst0 = 1'b0;
        rst1 = 1'b0;
        chk_en = 1'b1;

        // Reset state and first allocations.
        set0(0, 0, 0, 0, 0);
        chk("lit_reset_next", 64'(nid0), 64'd0);
        chk("lit_reset_lane1", 64'(ids0[W0 +: W0]), 64'd1);
        for (int k = 0; k < 3; k++) begin
            set0(2, 0, 0, 0, 0);
            chk("lit_ids_lane0", 64'(ids0[0 +: W0]), 64'(2 * k));
            chk("lit_ids_lane1", 64'(ids0[W0 +: W0]), 64'(2 * k + 1));
            tick();
        end
        set0(0, 0, 0, 0, 0);
        chk("lit_next6", 64'(nid0), 64'd6);
        chk("lit_inflight6", 64'(inf0), 64'd6);

        // Fill to capacity, then reject at inflight=16.
        for (int k = 3; k < 8; k++) begin
            set0(2, 0, 0, 0, 0);
            chk("lit_fill_ready", 64'(rdy0), 64'd1);
            tick();
        end
        set0(2, 0, 0, 0, 0);
        chk("lit_full_ready2", 64'(rdy0), 64'd0);
        tick();
        set0(1, 0, 0, 0, 0);
        chk("lit_full_ready1", 64'(rdy0), 64'd0);
        tick();
        set0(3, 0, 0, 0, 0);
        chk("lit_illegal_cnt_ready", 64'(rdy0), 64'd1);
        tick();
        set0(1, 1, 0, 0, 0);
        chk("lit_commit_same_cycle_ready", 64'(rdy0), 64'd0);
        tick();
        set0(1, 0, 0, 0, 0);
        chk("lit_after_commit_ready", 64'(rdy0), 64'd1);
        tick();
        set0(0, 0, 0, 0, 0);
        chk("lit_next17", 64'(nid0), 64'd17);
        chk("lit_retire1", 64'(rid0), 64'd1);

        // Reset wins over simultaneous alloc/commit.
        rst0 = 1'b1;
        set0(2, 1, 1, 0, 0);
        tick();
        rst0 = 1'b0;
        set0(0, 0, 0, 0, 0);
        chk("lit_reset_wins", 64'(nid0), 64'd0);

        // Commit with nothing in flight.
        set0(0, 1, 0, 0, 0);
        tick();
        set0(0, 0, 0, 0, 0);
        chk("lit_commit_empty_err", 64'(ce0), 64'd1);

        // Ordered commits, out-of-order commit, flushes.
        reset0();
        for (int k = 0; k < 5; k++) begin set0(2, 0, 0, 0, 0); tick(); end
        for (int k = 0; k < 3; k++) begin set0(0, 1, 64'(k), 0, 0); tick(); end
        set0(0, 0, 0, 0, 0);
        chk("lit_retire3", 64'(rid0), 64'd3);
        set0(0, 1, 5, 0, 0);
        tick();
        set0(0, 0, 0, 0, 0);
        chk("lit_commit5_err", 64'(ce0), 64'd1);
        chk("lit_commit5_retire", 64'(rid0), 64'd3);
        set0(2, 0, 0, 1, 6);
        chk("lit_flush_blocks_alloc", 64'(rdy0), 64'd0);
        tick();
        set0(0, 0, 0, 0, 0);
        chk("lit_flush6_next", 64'(nid0), 64'd7);
        chk("lit_flush6_inflight", 64'(inf0), 64'd4);
        set0(0, 0, 0, 1, 2);
        tick();
        set0(0, 0, 0, 0, 0);
        chk("lit_flush2_next", 64'(nid0), 64'd3);
        chk("lit_flush2_inflight", 64'(inf0), 64'd0);
        chk("lit_flush2_noerr", 64'(fe0), 64'd0);
        set0(0, 0, 0, 1, 9);
        tick();
        set0(0, 0, 0, 0, 0);
        chk("lit_flush9_err", 64'(fe0), 64'd1);
        chk("lit_flush9_next", 64'(nid0), 64'd3);

        // Same-cycle commit + flush: flush checked against post-commit retire.
        reset0();
        set0(2, 0, 0, 0, 0); tick();
        set0(2, 0, 0, 0, 0); tick();
        set0(1, 0, 0, 0, 0); tick();
        for (int k = 0; k < 3; k++) begin set0(0, 1, 64'(k), 0, 0); tick(); end
        set0(0, 1, 3, 1, 2);
        tick();
        set0(0, 0, 0, 0, 0);
        chk("lit_cf_flush_err", 64'(fe0), 64'd1);
        chk("lit_cf_retire4", 64'(rid0), 64'd4);
        chk("lit_cf_next5", 64'(nid0), 64'd5);
        chk("lit_cf_commit_ok", 64'(ce0), 64'd0);

        // Wrap-around on the 4-bit instance.
        for (int k = 0; k < 4; k++) begin set1(2, 0, 0, 0, 0); tick(); end
        for (int k = 0; k < 8; k++) begin set1(0, 1, 64'(k), 0, 0); tick(); end
        for (int k = 0; k < 3; k++) begin set1(2, 0, 0, 0, 0); tick(); end
        for (int k = 8; k < 14; k++) begin set1(0, 1, 64'(k), 0, 0); tick(); end
        set1(2, 0, 0, 0, 0);
        chk("lit_wrap_ids_14", 64'(ids1[0 +: W1]), 64'd14);
        chk("lit_wrap_ids_15", 64'(ids1[W1 +: W1]), 64'd15);
        tick();
        set1(2, 0, 0, 0, 0);
        chk("lit_wrap_ids_0", 64'(ids1[0 +: W1]), 64'd0);
        chk("lit_wrap_ids_1", 64'(ids1[W1 +: W1]), 64'd1);
        tick();
        set1(0, 0, 0, 0, 0);
        chk("lit_wrap_next2", 64'(nid1), 64'd2);
        set1(0, 1, 14, 0, 0); tick();
        set1(0, 1, 15, 0, 0); tick();
        set1(0, 0, 0, 0, 0);
        chk("lit_wrap_retire0", 64'(rid1), 64'd0);
        chk("lit_wrap_inflight2", 64'(inf1), 64'd2);
        set1(0, 0, 0, 1, 15);
        tick();
        set1(0, 0, 0, 0, 0);
        chk("lit_wrap_flush_next", 64'(nid1), 64'd0);
        chk("lit_wrap_flush_inflight", 64'(inf1), 64'd0);
        chk("lit_wrap_flush_noerr", 64'(fe1), 64'd0);

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
